// File: rtl/uart_tx_fifo_cfg.sv
// ============================================================================
// uart_tx_fifo_cfg : UART transmitter with write FIFO and runtime frame format
// Revision: 1.0
// ============================================================================
`default_nettype none

module uart_tx_fifo_cfg #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          tr_en,
  input  logic [CNT_W-1:0]              comp,
  input  logic [1:0]                    data_len,
  input  logic                          par_en,
  input  logic                          par_odd,
  input  logic                          stop2,
  input  logic [7:0]                    wr_data,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
  output logic                          busy,
  output logic                          uart_tx
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW:0] C_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      cnt_q;
  logic             push, pop;
  logic             w_flush, w_can_pop, w_last;
  logic [7:0]       w_mask, w_head_m;
  logic             w_par;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] per_q, per_d;
  logic [2:0]       bit_q, bit_d;
  logic             stop_q, stop_d;
  logic [7:0]       sh_q, sh_d;
  logic             par_q, par_d;
  logic             tx_q, tx_d;
  logic [CNT_W-1:0] comp_q, comp_d;
  logic [1:0]       len_q, len_d;
  logic             pen_q, pen_d;
  logic             s2_q, s2_d;

  assign w_flush   = !resetn || !tr_en;
  // Ready looks only at registered occupancy: a same-edge pop never frees a slot early.
  assign wr_ready  = resetn && tr_en && (cnt_q != C_FULL);
  assign push      = wr_valid && wr_ready;
  assign w_can_pop = tr_en && (cnt_q != '0);
  assign fifo_cnt  = cnt_q;
  assign busy      = (state_q != S_IDLE);
  assign uart_tx   = tx_q;

  assign w_mask   = 8'hFF >> (2'd3 - data_len);
  assign w_head_m = mem_q[rptr_q] & w_mask;
  assign w_par    = (^w_head_m) ^ par_odd;
  assign w_last   = (per_q == comp_q);

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (w_flush) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    per_d   = per_q;
    bit_d   = bit_q;
    stop_d  = stop_q;
    sh_d    = sh_q;
    par_d   = par_q;
    tx_d    = tx_q;
    comp_d  = comp_q;
    len_d   = len_q;
    pen_d   = pen_q;
    s2_d    = s2_q;
    pop     = 1'b0;

    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (w_can_pop) pop = 1'b1;
      end
      S_START: begin
        if (w_last) begin
          per_d   = '0;
          bit_d   = 3'd0;
          tx_d    = sh_q[0];
          state_d = S_DATA;
        end else begin
          per_d = per_q + 1'b1;
        end
      end
      S_DATA: begin
        if (w_last) begin
          per_d = '0;
          // Last data bit index is data_len+4, i.e. {1, len}.
          if (bit_q == {1'b1, len_q}) begin
            if (pen_q) begin
              tx_d    = par_q;
              state_d = S_PARITY;
            end else begin
              tx_d    = 1'b1;
              stop_d  = 1'b0;
              state_d = S_STOP;
            end
          end else begin
            bit_d = bit_q + 3'd1;
            sh_d  = sh_q >> 1;
            tx_d  = sh_q[1];
          end
        end else begin
          per_d = per_q + 1'b1;
        end
      end
      S_PARITY: begin
        if (w_last) begin
          per_d   = '0;
          tx_d    = 1'b1;
          stop_d  = 1'b0;
          state_d = S_STOP;
        end else begin
          per_d = per_q + 1'b1;
        end
      end
      S_STOP: begin
        if (w_last) begin
          per_d = '0;
          if (s2_q && !stop_q) begin
            stop_d = 1'b1;
          end else if (w_can_pop) begin
            pop = 1'b1;
          end else begin
            tx_d    = 1'b1;
            state_d = S_IDLE;
          end
        end else begin
          per_d = per_q + 1'b1;
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = S_IDLE;
      end
    endcase

    // Data and frame format are captured together so mid-frame edits wait a frame.
    if (pop) begin
      state_d = S_START;
      tx_d    = 1'b0;
      per_d   = '0;
      bit_d   = 3'd0;
      stop_d  = 1'b0;
      sh_d    = w_head_m;
      par_d   = w_par;
      comp_d  = comp;
      len_d   = data_len;
      pen_d   = par_en;
      s2_d    = stop2;
    end
  end

  always_ff @(posedge clk) begin
    if (w_flush) begin
      state_q <= S_IDLE;
      per_q   <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      comp_q  <= '0;
      len_q   <= '0;
      pen_q   <= 1'b0;
      s2_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      per_q   <= per_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      comp_q  <= comp_d;
      len_q   <= len_d;
      pen_q   <= pen_d;
      s2_q    <= s2_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_fifo_cfg.sv
// ============================================================================
// tb_uart_tx_fifo_cfg : table vectors, directed corner sequences and random
// traffic checked against a frame-level queue model of the transmitter.
// ============================================================================
`default_nettype none

module tb_uart_tx_fifo_cfg;

  localparam int DEPTH = 4;
  localparam int CW    = 16;

  logic                     clk = 1'b0;
  logic                     resetn, tr_en, par_en, par_odd, stop2, wr_valid;
  logic [CW-1:0]            comp;
  logic [1:0]               data_len;
  logic [7:0]               wr_data;
  logic                     wr_ready, busy, uart_tx;
  logic [$clog2(DEPTH):0]   fifo_cnt;

  int errors = 0;
  int checks = 0;

  uart_tx_fifo_cfg #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .tr_en    (tr_en),
    .comp     (comp),
    .data_len (data_len),
    .par_en   (par_en),
    .par_odd  (par_odd),
    .stop2    (stop2),
    .wr_data  (wr_data),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .fifo_cnt (fifo_cnt),
    .busy     (busy),
    .uart_tx  (uart_tx)
  );

  always #5 clk = ~clk;

  // Reference model: queued bytes plus the per-cycle line levels of the frame in flight.
  bit         lv[$];
  logic [7:0] mf[$];

  typedef struct {
    logic [15:0] comp;
    logic [1:0]  dl;
    logic        pe;
    logic        po;
    logic        s2;
    logic [7:0]  d;
    int          len;
    logic [11:0] bits;   // bit i = line level of frame bit i
  } vec_t;

  vec_t tv[5];

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got=%0d exp=%0d at %0t", name, got, exp, $time);
    end
  endtask

  function automatic void add_lvl(input bit b, input int reps);
    for (int r = 0; r < reps; r++) lv.push_back(b);
  endfunction

  function automatic void expand(input logic [7:0] d);
    int reps = int'(comp) + 1;
    int nb   = int'(data_len) + 5;
    bit p    = par_odd;
    add_lvl(1'b0, reps);
    for (int i = 0; i < nb; i++) begin
      add_lvl(d[i], reps);
      p = p ^ d[i];
    end
    if (par_en) add_lvl(p, reps);
    add_lvl(1'b1, stop2 ? 2 * reps : reps);
  endfunction

  function automatic void model_edge();
    bit can_push;
    if (!resetn || !tr_en) begin
      lv.delete();
      mf.delete();
    end else begin
      can_push = (mf.size() < DEPTH);
      if (lv.size() > 0) void'(lv.pop_front());
      if (lv.size() == 0 && mf.size() > 0) expand(mf.pop_front());
      if (wr_valid && can_push) mf.push_back(wr_data);
    end
  endfunction

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    chk("m_uart_tx",  int'(uart_tx),  (lv.size() > 0) ? int'(lv[0]) : 1);
    chk("m_busy",     int'(busy),     (lv.size() > 0) ? 1 : 0);
    chk("m_fifo_cnt", int'(fifo_cnt), mf.size());
    chk("m_wr_ready", int'(wr_ready), (resetn && tr_en && mf.size() < DEPTH) ? 1 : 0);
  endtask

  task automatic wait_idle(input int maxc, output int n);
    n = 0;
    while (busy && n < maxc) begin
      step();
      n++;
    end
    if (busy) begin
      errors++;
      checks++;
      $display("FAIL wait_idle_timeout: got=busy exp=idle within %0d cycles", maxc);
    end
  endtask

  task automatic set_cfg(input int c, input int dl, input bit pe, input bit po, input bit s2);
    comp     = CW'(c);
    data_len = 2'(dl);
    par_en   = pe;
    par_odd  = po;
    stop2    = s2;
  endtask

  initial begin
    int n;

    tv[0] = '{16'd3, 2'd3, 1'b0, 1'b0, 1'b0, 8'hA5, 10, 12'b00_1101001010};
    tv[1] = '{16'd1, 2'd0, 1'b1, 1'b0, 1'b1, 8'h17,  9, 12'b000_110101110};
    tv[2] = '{16'd1, 2'd0, 1'b1, 1'b1, 1'b1, 8'h17,  9, 12'b000_111101110};
    tv[3] = '{16'd0, 2'd2, 1'b1, 1'b1, 1'b0, 8'hFF, 10, 12'b00_1011111110};
    tv[4] = '{16'd2, 2'd1, 1'b0, 1'b0, 1'b1, 8'hC2,  9, 12'b000_110000100};

    resetn = 1'b0; tr_en = 1'b1; wr_valid = 1'b0; wr_data = 8'h00;
    set_cfg(3, 3, 1'b0, 1'b0, 1'b0);
    step();
    step();
    chk("rst_uart_tx",  int'(uart_tx),  1);
    chk("rst_busy",     int'(busy),     0);
    chk("rst_fifo_cnt", int'(fifo_cnt), 0);
    chk("rst_wr_ready", int'(wr_ready), 0);
    resetn = 1'b1;
    step();

    // Table-driven single frames.
    for (int v = 0; v < 5; v++) begin
      set_cfg(int'(tv[v].comp), int'(tv[v].dl), tv[v].pe, tv[v].po, tv[v].s2);
      wr_data  = tv[v].d;
      wr_valid = 1'b1;
      step();
      wr_valid = 1'b0;
      for (int i = 0; i < tv[v].len; i++) begin
        for (int c = 0; c <= int'(tv[v].comp); c++) begin
          step();
          chk($sformatf("vec%0d_bit%0d", v, i), int'(uart_tx), int'(tv[v].bits[i]));
        end
      end
      step();
      chk($sformatf("vec%0d_busy_end", v), int'(busy), 0);
    end

    // Back-to-back frames filling the FIFO.
    set_cfg(0, 3, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      wr_valid = 1'b1;
      wr_data  = 8'h30 + 8'(k);
      step();
    end
    chk("b2b_full_cnt",   int'(fifo_cnt), 4);
    chk("b2b_full_ready", int'(wr_ready), 0);
    wr_valid = 1'b0;
    wait_idle(200, n);
    chk("b2b_busy_len", n, 47);

    // Push on the same edge IDLE pops the only entry.
    set_cfg(1, 3, 1'b0, 1'b0, 1'b0);
    wr_valid = 1'b1; wr_data = 8'h11;
    step();
    wr_data = 8'h22;
    step();
    chk("pp_fifo_cnt", int'(fifo_cnt), 1);
    chk("pp_busy",     int'(busy),     1);
    wr_valid = 1'b0;
    wait_idle(200, n);
    chk("pp_busy_len", n, 40);

    // Abort mid-DATA with two bytes queued, then a clean frame.
    set_cfg(3, 3, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      wr_valid = 1'b1;
      wr_data  = 8'h81 + 8'(k);
      step();
    end
    wr_valid = 1'b0;
    repeat (8) step();
    chk("ab_queued", int'(fifo_cnt), 2);
    tr_en = 1'b0; wr_valid = 1'b1; wr_data = 8'h55;
    step();
    chk("ab_uart_tx",  int'(uart_tx),  1);
    chk("ab_busy",     int'(busy),     0);
    chk("ab_fifo_cnt", int'(fifo_cnt), 0);
    chk("ab_wr_ready", int'(wr_ready), 0);
    step();
    chk("ab_drop_cnt", int'(fifo_cnt), 0);
    tr_en = 1'b1; wr_data = 8'h3C;
    step();
    wr_valid = 1'b0;
    step();
    wait_idle(200, n);
    chk("ab_clean_len", n, 40);
    chk("ab_clean_cnt", int'(fifo_cnt), 0);

    // comp changes during DATA of the first frame.
    set_cfg(3, 3, 1'b0, 1'b0, 1'b0);
    wr_valid = 1'b1; wr_data = 8'h96;
    step();
    wr_data = 8'h69;
    step();
    wr_valid = 1'b0;
    repeat (10) step();
    comp = 16'd7;
    wait_idle(400, n);
    chk("cfg_busy_len", n, 110);

    // Random traffic, format changes, aborts and resets against the model.
    for (int t = 0; t < 1500; t++) begin
      wr_valid = ($urandom_range(0, 2) != 0);
      wr_data  = 8'($urandom);
      if ($urandom_range(0, 29) == 0)
        set_cfg($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), 1'($urandom), 1'($urandom));
      tr_en  = ($urandom_range(0, 149) != 0);
      resetn = ($urandom_range(0, 299) != 0);
      step();
    end
    resetn = 1'b1; tr_en = 1'b1; wr_valid = 1'b0;
    step();
    wait_idle(2000, n);
    chk("rnd_final_cnt", int'(fifo_cnt), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
